// File: rtl/nand_gate_tester.sv
// Go/no-go tester for a quad 2-input NAND: drives A/B vectors, waits to settle, checks Y.
// Define NAND_TESTER_WALK_EN to append four walking-one vectors that expose swapped/shorted outputs.
module nand_gate_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [3:0] fail_mask
);
  localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW = (SC < 2) ? 1 : $clog2(SC);
`ifdef NAND_TESTER_WALK_EN
  localparam int N  = 8;
  localparam int IW = 3;
`else
  localparam int N  = 4;
  localparam int IW = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_a, r_b, r_mask;
  logic [5:0]      r_err;

  logic            w_last, w_settled;
  logic [IW-1:0]   w_idx_nxt;
  logic [3:0]      w_mis;
  logic [2:0]      w_pop;
  logic [6:0]      w_sum;
  logic [5:0]      w_err_sat;

  // Base vectors put the same AB pair on every gate; walk vectors single out one gate each.
  function automatic logic [3:0] vec_a(input logic [IW-1:0] idx);
`ifdef NAND_TESTER_WALK_EN
    if (idx[2]) return 4'b0001 << idx[1:0];
`endif
    return {4{idx[1]}};
  endfunction

  function automatic logic [3:0] vec_b(input logic [IW-1:0] idx);
`ifdef NAND_TESTER_WALK_EN
    if (idx[2]) return 4'b1111;
`endif
    return {4{idx[0]}};
  endfunction

  assign w_last    = (r_idx == IW'(N - 1));
  assign w_settled = (r_cnt == CW'(SC - 1));
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_mis     = Y ^ ~(r_a & r_b);

  always_comb begin
    w_pop = 3'd0;
    for (int i = 0; i < 4; i++) w_pop = w_pop + {2'b00, w_mis[i]};
  end

  assign w_sum     = {1'b0, r_err} + {4'b0000, w_pop};
  assign w_err_sat = w_sum[6] ? 6'd63 : w_sum[5:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_SETTLE;
      S_SETTLE:       if (w_settled) w_next = S_CHECK;
      S_CHECK:        w_next = w_last ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_err   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_err  <= '0;
          r_mask <= '0;
          r_idx  <= '0;
          r_cnt  <= '0;
          r_a    <= vec_a('0);
          r_b    <= vec_b('0);
        end
        S_SETTLE: if (!w_settled) r_cnt <= r_cnt + 1'b1;
        S_CHECK: begin
          r_err  <= w_err_sat;
          r_mask <= r_mask | w_mis;
          r_cnt  <= '0;
          if (!w_last) begin
            r_idx <= w_idx_nxt;
            r_a   <= vec_a(w_idx_nxt);
            r_b   <= vec_b(w_idx_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err == 6'd0);
  assign err_count = r_err;
  assign fail_mask = r_mask;
endmodule

// File: tb/tb_nand_gate_tester.sv
// Bench for nand_gate_tester: behavioural NAND with injectable faults, directed table plus random fault runs.
module tb_nand_gate_tester;
`ifdef NAND_TESTER_WALK_EN
  localparam int  N    = 8;
  localparam bit  WALK = 1'b1;
`else
  localparam int  N    = 4;
  localparam bit  WALK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, start0;
  logic [3:0] A, B, Y, A0, B0, Y0;
  logic busy, done, pass, busy0, done0, pass0;
  logic [5:0] err_count, err0;
  logic [3:0] fail_mask, mask0;

  int mode = 0;
  bit glitch_en = 1'b0;
  logic [7:0][3:0] fx = '0;
  logic [7:0] ab_q = '0;
  logic [3:0] glitch_rand = '0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  nand_gate_tester #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Y(Y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask));

  nand_gate_tester #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(A0), .B(B0), .Y(Y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0));

  function automatic logic [3:0] va(input int v);
    if (v < 4) return (v >= 2) ? 4'hF : 4'h0;
    return 4'(1 << (v - 4));
  endfunction

  function automatic logic [3:0] vb(input int v);
    if (v < 4) return (v % 2 == 1) ? 4'hF : 4'h0;
    return 4'hF;
  endfunction

  // Device-under-test stand-in: 0 good, 1 Y2 stuck low, 2 Y0/Y1 swapped, 3 per-vector XOR faults.
  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input int m, input logic [7:0][3:0] f);
    logic [3:0] y;
    y = ~(a & b);
    if (m == 1) y[2] = 1'b0;
    else if (m == 2) y = {y[3:2], y[0], y[1]};
    else if (m == 3)
      for (int v = 0; v < N; v++) if (a == va(v) && b == vb(v)) y = y ^ f[v];
    return y;
  endfunction

  // Garbage on Y for the first cycle after A/B move; that cycle is always inside SETTLE.
  always @(posedge clk) begin
    ab_q        <= {A, B};
    glitch_rand <= 4'($urandom);
  end

  always_comb begin
    Y  = model(A, B, mode, fx);
    if (glitch_en && ({A, B} != ab_q)) Y = glitch_rand;
    Y0 = model(A0, B0, mode, fx);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Starts a run on the main DUT and counts busy cycles until done (bounded).
  task automatic run(input bit hold, output int bc, output bit to);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    bc = 0;
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin to = 1'b0; break; end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string      name;
    int         mode;
    int         err;
    logic [3:0] mask;
    bit         pass;
  } vec_t;

  vec_t tbl[3];
  int   bc;
  bit   to;

  initial begin
    tbl[0] = '{"good",  0, 0,              4'b0000,                   1'b1};
    tbl[1] = '{"stuck", 1, WALK ? 6 : 3,   4'b0100,                   1'b0};
    tbl[2] = '{"swap",  2, WALK ? 4 : 0,   WALK ? 4'b0011 : 4'b0000,  !WALK};

    rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ab", {A, B}, 0);
    chk("rst_err", err_count, 0);
    chk("rst_mask", fail_mask, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      run(1'b0, bc, to);
      chk({tbl[i].name, "_timeout"}, to, 0);
      chk({tbl[i].name, "_cycles"}, bc, N * 5);
      chk({tbl[i].name, "_err"}, err_count, tbl[i].err);
      chk({tbl[i].name, "_mask"}, fail_mask, tbl[i].mask);
      chk({tbl[i].name, "_pass"}, pass, tbl[i].pass);
      chk({tbl[i].name, "_last_ab"}, {A, B}, {va(N - 1), vb(N - 1)});
    end

    // Results and last vector hold in DONE.
    repeat (3) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_err", err_count, tbl[2].err);
    chk("hold_ab", {A, B}, {va(N - 1), vb(N - 1)});

    // Reset during the second vector's SETTLE discards the partial run.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_vec1_ab", {A, B}, {va(1), vb(1)});
    chk("mid_partial_err", err_count, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ab", {A, B}, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_mask", fail_mask, 0);
    @(negedge clk);
    chk("mid_idle", busy, 0);
    mode = 0;
    run(1'b0, bc, to);
    chk("fresh_timeout", to, 0);
    chk("fresh_cycles", bc, N * 5);
    chk("fresh_pass", pass, 1);

    // start held high: no restart while busy, then DONE for one cycle straight into SETTLE.
    mode = 1;
    run(1'b1, bc, to);
    chk("held_timeout", to, 0);
    chk("held_cycles", bc, N * 5);
    chk("held_err", err_count, WALK ? 6 : 3);
    @(negedge clk);
    start = 1'b0;
    chk("held_done_gone", done, 0);
    chk("held_busy", busy, 1);
    chk("held_err_clr", err_count, 0);
    chk("held_mask_clr", fail_mask, 0);
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk("held_rerun_timeout", to, 0);
    chk("held_rerun_err", err_count, WALK ? 6 : 3);

    // SETTLE_CYCLES=0 instance behaves as 1.
    mode = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    bc = 0;
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done0) begin to = 1'b0; break; end
      if (busy0) bc++;
      @(negedge clk);
    end
    chk("sc0_timeout", to, 0);
    chk("sc0_cycles", bc, N * 2);
    chk("sc0_pass", pass0, 1);
    chk("sc0_err", err0, 0);

    // Random per-vector faults with Y glitching during SETTLE.
    mode = 3;
    glitch_en = 1'b1;
    for (int r = 0; r < 15; r++) begin
      int         exp_err;
      logic [3:0] exp_mask;
      exp_err = 0;
      exp_mask = '0;
      for (int v = 0; v < 8; v++) fx[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      for (int v = 0; v < N; v++) begin
        exp_err += $countones(fx[v]);
        exp_mask |= fx[v];
      end
      run(1'b0, bc, to);
      chk("rnd_timeout", to, 0);
      chk("rnd_cycles", bc, N * 5);
      chk("rnd_err", err_count, exp_err);
      chk("rnd_mask", fail_mask, exp_mask);
      chk("rnd_pass", pass, exp_err == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
